// File: rtl/regfile_write_arbiter_if.sv
// Writeback requester handshakes, register-file write port and stall-logic probe
// shared between the write arbiter and its neighbours.
interface regfile_write_arbiter_if #(
  parameter int WIDTH  = 64,
  parameter int ADDR_W = 5
);
  logic              req0_valid;
  logic              req0_ready;
  logic [ADDR_W-1:0] req0_addr;
  logic [WIDTH-1:0]  req0_data;
  logic              req1_valid;
  logic              req1_ready;
  logic [ADDR_W-1:0] req1_addr;
  logic [WIDTH-1:0]  req1_data;
  logic              writeEnable;
  logic [ADDR_W-1:0] writeAddr;
  logic [WIDTH-1:0]  writeData;
  logic [ADDR_W-1:0] readAddr;
  logic              pendingMatch;

  modport master (
    output req0_valid, req0_addr, req0_data,
    output req1_valid, req1_addr, req1_data,
    output readAddr,
    input  req0_ready, req1_ready,
    input  writeEnable, writeAddr, writeData,
    input  pendingMatch
  );

  modport slave (
    input  req0_valid, req0_addr, req0_data,
    input  req1_valid, req1_addr, req1_data,
    input  readAddr,
    output req0_ready, req1_ready,
    output writeEnable, writeAddr, writeData,
    output pendingMatch
  );
endinterface

// File: rtl/regfile_write_arbiter.sv
// Two-requester register-file write arbiter: one holding slot per requester,
// round-robin grant between occupied slots, registered write port.
module regfile_write_arbiter #(
  parameter int WIDTH    = 64,
  parameter int ADDR_W   = 5,
  parameter int ZERO_REG = 31
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    flush,
  regfile_write_arbiter_if.slave  bus
);
  localparam logic [ADDR_W-1:0] ZERO_ADDR = ADDR_W'(ZERO_REG);

  logic [1:0]        req_valid;
  logic [1:0]        req_ready;
  logic [ADDR_W-1:0] req_addr [2];
  logic [WIDTH-1:0]  req_data [2];

  logic [1:0]        slot_valid;
  logic [ADDR_W-1:0] slot_addr [2];
  logic [WIDTH-1:0]  slot_data [2];
  logic [1:0]        grant;

  logic              ptr_reg;
  logic              write_en_reg;
  logic [ADDR_W-1:0] write_addr_reg;
  logic [WIDTH-1:0]  write_data_reg;

  logic              issue;
  logic [ADDR_W-1:0] grant_addr;
  logic [WIDTH-1:0]  grant_data;
  logic              pending_next;

  assign req_valid[0] = bus.req0_valid;
  assign req_valid[1] = bus.req1_valid;
  assign req_addr[0]  = bus.req0_addr;
  assign req_addr[1]  = bus.req1_addr;
  assign req_data[0]  = bus.req0_data;
  assign req_data[1]  = bus.req1_data;

  assign bus.req0_ready = req_ready[0];
  assign bus.req1_ready = req_ready[1];

  // Pointer names the requester that wins when both slots are occupied.
  assign grant[0] = slot_valid[0] & (~slot_valid[1] | ~ptr_reg);
  assign grant[1] = slot_valid[1] & (~slot_valid[0] |  ptr_reg);

  // A grant in the flush cycle is dropped along with the slot contents.
  assign issue      = (|grant) & ~flush;
  assign grant_addr = grant[1] ? slot_addr[1] : slot_addr[0];
  assign grant_data = grant[1] ? slot_data[1] : slot_data[0];

  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_slot
      logic              valid_reg;
      logic [ADDR_W-1:0] addr_reg;
      logic [WIDTH-1:0]  data_reg;
      logic              take;

      // A granted slot frees up in the same cycle, so it can be refilled back-to-back.
      assign req_ready[gi]  = ~reset & ~flush & (~valid_reg | grant[gi]);
      assign take           = req_valid[gi] & req_ready[gi];
      assign slot_valid[gi] = valid_reg;
      assign slot_addr[gi]  = addr_reg;
      assign slot_data[gi]  = data_reg;

      always_ff @(posedge clk) begin
        if (reset) begin
          valid_reg <= 1'b0;
          addr_reg  <= '0;
          data_reg  <= '0;
        end else if (flush) begin
          valid_reg <= 1'b0;
        end else if (take) begin
          valid_reg <= 1'b1;
          addr_reg  <= req_addr[gi];
          data_reg  <= req_data[gi];
        end else if (grant[gi]) begin
          valid_reg <= 1'b0;
        end
      end
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (reset) begin
      ptr_reg        <= 1'b0;
      write_en_reg   <= 1'b0;
      write_addr_reg <= '0;
      write_data_reg <= '0;
    end else if (issue) begin
      ptr_reg        <= grant[0];
      write_en_reg   <= (grant_addr != ZERO_ADDR);
      write_addr_reg <= grant_addr;
      write_data_reg <= grant_data;
    end else begin
      write_en_reg   <= 1'b0;
    end
  end

  assign bus.writeEnable = write_en_reg;
  assign bus.writeAddr   = write_addr_reg;
  assign bus.writeData   = write_data_reg;

  always_comb begin
    pending_next = 1'b0;
    if (bus.readAddr != ZERO_ADDR) begin
      pending_next = (slot_valid[0] && slot_addr[0] == bus.readAddr) ||
                     (slot_valid[1] && slot_addr[1] == bus.readAddr) ||
                     (write_en_reg  && write_addr_reg == bus.readAddr);
    end
  end

  assign bus.pendingMatch = pending_next;
endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Directed bench for regfile_write_arbiter: inputs change 1ns after posedge,
// outputs are sampled on negedge against hand-computed values.
module tb_regfile_write_arbiter;
  logic clk;
  logic reset;
  logic flush;
  int   n_checks;
  int   n_fail;

  regfile_write_arbiter_if #(.WIDTH(64), .ADDR_W(5)) bus ();

  regfile_write_arbiter #(.WIDTH(64), .ADDR_W(5), .ZERO_REG(31)) dut (
    .clk   (clk),
    .reset (reset),
    .flush (flush),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.req0_valid = 1'b0;
    bus.req1_valid = 1'b0;
  endtask

  task automatic drive0(input logic [4:0] a, input logic [63:0] d);
    bus.req0_valid = 1'b1;
    bus.req0_addr  = a;
    bus.req0_data  = d;
  endtask

  task automatic drive1(input logic [4:0] a, input logic [63:0] d);
    bus.req1_valid = 1'b1;
    bus.req1_addr  = a;
    bus.req1_data  = d;
  endtask

  logic [63:0] exp_a [8] = '{64'd1, 64'd11, 64'd2, 64'd12, 64'd3, 64'd13, 64'd4, 64'd14};
  logic [63:0] exp_d [8] = '{64'h100, 64'h200, 64'h101, 64'h201, 64'h102, 64'h202, 64'h103, 64'h203};

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int i0;
    int i1;
    int wcnt;
    int last_w;
    n_checks = 0;
    n_fail   = 0;
    reset    = 1'b1;
    flush    = 1'b0;
    idle_inputs();
    bus.req0_addr = '0;
    bus.req0_data = '0;
    bus.req1_addr = '0;
    bus.req1_data = '0;
    bus.readAddr  = '0;

    // Reset and idle
    @(negedge clk);
    check_eq("rst_ready0", bus.req0_ready, 0);
    check_eq("rst_ready1", bus.req1_ready, 0);
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    check_eq("idle_we", bus.writeEnable, 0);
    check_eq("idle_waddr", bus.writeAddr, 0);
    check_eq("idle_wdata", bus.writeData, 0);
    check_eq("idle_ready0", bus.req0_ready, 1);
    check_eq("idle_ready1", bus.req1_ready, 1);
    for (int a = 0; a < 32; a++) begin
      bus.readAddr = 5'(a);
      #1;
      check_eq($sformatf("idle_pm%0d", a), bus.pendingMatch, 0);
    end

    // Single write, 2-cycle latency
    cyc();
    drive0(5'd5, 64'hAAAA);
    bus.readAddr = 5'd5;
    @(negedge clk);
    check_eq("single_ready0", bus.req0_ready, 1);
    check_eq("single_pm_pre", bus.pendingMatch, 0);
    cyc();
    idle_inputs();
    @(negedge clk);
    check_eq("single_we_k1", bus.writeEnable, 0);
    check_eq("single_pm_slot", bus.pendingMatch, 1);
    cyc();
    @(negedge clk);
    check_eq("single_we", bus.writeEnable, 1);
    check_eq("single_waddr", bus.writeAddr, 5);
    check_eq("single_wdata", bus.writeData, 64'hAAAA);
    check_eq("single_pm_wr", bus.pendingMatch, 1);
    $display("write addr=%0d data=%0h", bus.writeAddr, bus.writeData);
    cyc();
    @(negedge clk);
    check_eq("single_we_off", bus.writeEnable, 0);
    check_eq("single_pm_done", bus.pendingMatch, 0);

    // Fresh reset so the pointer starts at requester 0
    cyc();
    reset = 1'b1;
    cyc();
    reset = 1'b0;

    // Both requesters continuously valid
    i0 = 0;
    i1 = 0;
    wcnt = 0;
    last_w = -1;
    for (int c = 0; c < 14; c++) begin
      cyc();
      bus.req0_valid = (i0 < 4);
      bus.req0_addr  = 5'(1 + i0);
      bus.req0_data  = 64'h100 + 64'(i0);
      bus.req1_valid = (i1 < 4);
      bus.req1_addr  = 5'(11 + i1);
      bus.req1_data  = 64'h200 + 64'(i1);
      @(negedge clk);
      if (c <= 6) begin
        check_eq($sformatf("rr_ready0_c%0d", c), bus.req0_ready, (c == 0) || (c % 2 == 1));
        check_eq($sformatf("rr_ready1_c%0d", c), bus.req1_ready, (c == 0) || (c % 2 == 0));
      end
      if (bus.writeEnable) begin
        $display("write addr=%0d data=%0h", bus.writeAddr, bus.writeData);
        if (wcnt < 8) begin
          check_eq($sformatf("rr_addr%0d", wcnt), bus.writeAddr, exp_a[wcnt]);
          check_eq($sformatf("rr_data%0d", wcnt), bus.writeData, exp_d[wcnt]);
        end
        if (wcnt > 0) check_eq($sformatf("rr_gap%0d", wcnt), c, last_w + 1);
        wcnt++;
        last_w = c;
      end
      if (bus.req0_valid && bus.req0_ready) i0++;
      if (bus.req1_valid && bus.req1_ready) i1++;
    end
    idle_inputs();
    check_eq("rr_count", wcnt, 8);

    // Zero-register write followed by a normal write
    cyc();
    drive1(5'd31, 64'hFFFF);
    bus.readAddr = 5'd31;
    @(negedge clk);
    check_eq("zr_ready1", bus.req1_ready, 1);
    check_eq("zr_pm_a", bus.pendingMatch, 0);
    cyc();
    idle_inputs();
    drive0(5'd3, 64'h1);
    @(negedge clk);
    check_eq("zr_ready0", bus.req0_ready, 1);
    check_eq("zr_pm_b", bus.pendingMatch, 0);
    cyc();
    idle_inputs();
    @(negedge clk);
    check_eq("zr_we", bus.writeEnable, 0);
    check_eq("zr_waddr", bus.writeAddr, 31);
    check_eq("zr_pm_c", bus.pendingMatch, 0);
    cyc();
    @(negedge clk);
    check_eq("zr_next_we", bus.writeEnable, 1);
    check_eq("zr_next_addr", bus.writeAddr, 3);
    check_eq("zr_next_data", bus.writeData, 1);
    check_eq("zr_pm_d", bus.pendingMatch, 0);
    $display("write addr=%0d data=%0h", bus.writeAddr, bus.writeData);
    bus.readAddr = 5'd3;
    #1;
    check_eq("zr_pm_wr3", bus.pendingMatch, 1);

    // Flush with both slots full and a write already registered
    cyc();
    drive0(5'd6, 64'h66);
    @(negedge clk);
    check_eq("fl_ready0_a", bus.req0_ready, 1);
    cyc();
    drive0(5'd7, 64'h77);
    drive1(5'd8, 64'h88);
    @(negedge clk);
    check_eq("fl_ready0_b", bus.req0_ready, 1);
    check_eq("fl_ready1_b", bus.req1_ready, 1);
    cyc();
    idle_inputs();
    flush = 1'b1;
    bus.readAddr = 5'd7;
    @(negedge clk);
    check_eq("fl_ready0", bus.req0_ready, 0);
    check_eq("fl_ready1", bus.req1_ready, 0);
    check_eq("fl_prior_we", bus.writeEnable, 1);
    check_eq("fl_prior_addr", bus.writeAddr, 6);
    check_eq("fl_pm7_pre", bus.pendingMatch, 1);
    cyc();
    flush = 1'b0;
    @(negedge clk);
    check_eq("fl_we_after", bus.writeEnable, 0);
    check_eq("fl_pm7", bus.pendingMatch, 0);
    bus.readAddr = 5'd8;
    #1;
    check_eq("fl_pm8", bus.pendingMatch, 0);
    for (int k = 0; k < 5; k++) begin
      cyc();
      @(negedge clk);
      check_eq($sformatf("fl_quiet%0d", k), bus.writeEnable, 0);
    end

    // Reset with both slots full and a write pending; pointer held through flush
    cyc();
    drive0(5'd9, 64'h99);
    drive1(5'd10, 64'h1010);
    @(negedge clk);
    check_eq("rs_ready0_a", bus.req0_ready, 1);
    check_eq("rs_ready1_a", bus.req1_ready, 1);
    cyc();
    idle_inputs();
    @(negedge clk);
    check_eq("rs_ready0_b", bus.req0_ready, 0);
    check_eq("rs_ready1_b", bus.req1_ready, 1);
    cyc();
    reset = 1'b1;
    bus.readAddr = 5'd9;
    @(negedge clk);
    check_eq("rs_we_pre", bus.writeEnable, 1);
    check_eq("rs_addr_pre", bus.writeAddr, 10);
    check_eq("rs_data_pre", bus.writeData, 64'h1010);
    check_eq("rs_ready0_rst", bus.req0_ready, 0);
    check_eq("rs_ready1_rst", bus.req1_ready, 0);
    check_eq("rs_pm9_pre", bus.pendingMatch, 1);
    cyc();
    reset = 1'b0;
    @(negedge clk);
    check_eq("rs_we", bus.writeEnable, 0);
    check_eq("rs_waddr", bus.writeAddr, 0);
    check_eq("rs_wdata", bus.writeData, 0);
    check_eq("rs_ready0", bus.req0_ready, 1);
    check_eq("rs_ready1", bus.req1_ready, 1);
    check_eq("rs_pm9", bus.pendingMatch, 0);
    for (int k = 0; k < 4; k++) begin
      cyc();
      @(negedge clk);
      check_eq($sformatf("rs_quiet%0d", k), bus.writeEnable, 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/regfile_write_arbiter.md
Name: regfile_write_arbiter

Overview:
- Shares the register file's single write port between two writeback requesters: requester 0 is the ALU and requester 1 is the load unit.
- Each requester has a one-entry holding slot, so it is decoupled from the other.
- Arbitration between occupied slots is round-robin, and the write port is driven from a register.
- The block sits between the writeback sources and the register file's write-enable, address and data inputs. It also reports pending writes to the stall logic.

Parameters:
- WIDTH, 64, data width of one register.
- ADDR_W, 5, register address width.
- ZERO_REG, 31, hardwired-zero register index; writes to it are discarded.

Ports:
- clk  in  1  clock, all state updates on posedge.
- reset  in  1  synchronous, active-high.
- flush  in  1  synchronous; drops both holding slots.
- req0_valid  in  1  requester 0 has a write.
- req0_ready  out  1  requester 0 transfer accepted this cycle.
- req0_addr  in  ADDR_W  requester 0 destination register.
- req0_data  in  WIDTH  requester 0 write data.
- req1_valid, req1_ready, req1_addr, req1_data: same as requester 0, for requester 1.
- writeEnable  out  1  register file write enable.
- writeAddr  out  ADDR_W  register file write address.
- writeData  out  WIDTH  register file write data.
- readAddr  in  ADDR_W  address probed by the stall logic.
- pendingMatch  out  1  a queued or in-flight write targets readAddr.

Behaviour:
- Clocking and reset: single clock clk; reset is synchronous and active-high, sampled on posedge clk.
- Reset values:
  - both slots empty;
  - priority pointer = requester 0;
  - writeEnable = 0, writeAddr = 0, writeData = 0;
  - req0_ready = 0 and req1_ready = 0 during reset;
  - pendingMatch = 0.
- Reset mid-operation: all pending writes are lost and nothing is written.
- Handshake:
  - A transfer occurs on a posedge where reqN_valid && reqN_ready.
  - reqN_ready = !reset && !flush && (slotN empty || slotN granted this cycle). The ready is combinational from slot state; there is no path from valid to ready.
  - The requester must hold addr and data stable while valid is high and ready is low.
- Slot: stores {addr, data}. It is loaded on transfer and cleared when granted without a simultaneous refill.
- Arbitration (combinational, evaluated each cycle):
  - Only one slot occupied: grant it.
  - Both slots occupied: grant the requester named by the pointer.
  - After any grant, the pointer points to the other requester. With no grant, the pointer holds.
- Write port:
  - Registered. On a grant, the next posedge loads writeAddr and writeData from the granted slot.
  - writeEnable = 1 for exactly that cycle, unless addr == ZERO_REG.
  - With no grant, writeEnable = 0 and writeAddr/writeData hold their previous values.
- Latency and throughput:
  - A transfer at edge k into an empty, uncontended slot drives writeEnable during the cycle after edge k+1 (2 cycles).
  - Sustained throughput is one write per cycle in total. With both requesters always valid, each gets every other cycle.
- Zero register: a write to ZERO_REG is accepted and granted (the pointer advances), but writeEnable stays 0.
- Same-address writes from both requesters: no merging. They are written in grant order and the later write wins in the register file.
- flush:
  - Clears both slots at the posedge.
  - No new transfer is accepted (ready is low).
  - A grant in the flush cycle is suppressed, so writeEnable = 0 next cycle.
  - The write already in the output register still completes.
  - The pointer holds.
- reset has priority over flush.
- pendingMatch: combinational. It is 1 when readAddr != ZERO_REG and readAddr equals the addr of either occupied slot or writeAddr with writeEnable = 1.

Test Plan:
- Reset for 3 cycles, then idle → writeEnable = 0, both readies = 1, pendingMatch = 0 for readAddr = 0..31.
- req0 {addr 5, data 0xAAAA} for one cycle only → writeEnable = 1 with writeAddr = 5 and writeData = 0xAAAA exactly 2 cycles after the transfer, single-cycle pulse; pendingMatch = 1 for readAddr = 5 until that write cycle ends.
- Both requesters valid continuously (req0 addr 1..4, req1 addr 11..14) → write port sequence 1, 11, 2, 12, 3, 13, 4, 14, no gaps; each ready is high on alternate cycles once the slots fill.
- req1 write {31, 0xFFFF} followed by req0 write {3, 0x1} → the addr-31 transfer is accepted but writeEnable stays 0 in its slot; addr 3 is written next; pendingMatch = 0 for readAddr = 31 throughout.
- Fill both slots (addr 7 and 8), assert flush for 1 cycle → neither address is ever written and pendingMatch = 0 for 7 and 8 after the flush edge; a write registered before the flush still completes.
- Assert reset while both slots are full and a write is pending → all outputs return to reset values at the next edge and no stale write appears after reset deasserts.
